// File: rtl/rv_dmem_responder.sv
// ============================================================================
// Module      : rv_dmem_responder
// Description : Word-organised data RAM answering uRV load/store requests with
//               a ready/valid handshake, fixed wait states and a done pulse.
//               Define RV_DMEM_RANDOM_WAIT_EN to add 0..3 LFSR-driven waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rv_dmem_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o
);

    localparam int          c_depth     = 1 << ADDR_WIDTH;
    localparam logic [4:0]  c_wait_base = 5'(WAIT_STATES);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_wait   = 2'd1;
    localparam logic [1:0]  c_st_done   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [4:0]            r_cnt;
    logic [4:0]            w_cnt_nxt;
    logic [4:0]            w_wait;

    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_data;
    logic [3:0]            r_sel;
    logic                  r_store;

    logic [ADDR_WIDTH-1:0] w_op_idx;
    logic [31:0]           w_op_data;
    logic [3:0]            w_op_sel;
    logic                  w_op_store;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_enter_done;
    logic                  w_commit;

    logic [31:0]           r_data_l;
    logic                  r_load_done;
    logic                  r_store_done;

    logic [31:0]           r_mem [c_depth];

    logic                  w_unused_addr;

    assign w_ready  = (r_state != c_st_wait);
    assign w_accept = w_ready & (dm_load_i | dm_store_i);

`ifdef RV_DMEM_RANDOM_WAIT_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; steps once per accepted request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_wait = c_wait_base + {3'b000, r_lfsr[1:0]};
`else
    logic [15:0] w_unused_seed;

    assign w_unused_seed = LFSR_SEED;
    assign w_wait        = c_wait_base;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_wait: begin
                w_cnt_nxt = r_cnt - 5'd1;
                if (r_cnt <= 5'd1) begin
                    w_state_nxt = c_st_done;
                end
            end
            default: begin
                if (w_accept) begin
                    w_cnt_nxt   = w_wait;
                    w_state_nxt = (w_wait == 5'd0) ? c_st_done : c_st_wait;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    // A zero-wait request completes on its own acceptance edge, before the
    // latched copy exists, so the operation source bypasses the registers.
    assign w_op_idx   = w_accept ? dm_addr_i[ADDR_WIDTH+1:2] : r_idx;
    assign w_op_data  = w_accept ? dm_data_s_i               : r_data;
    assign w_op_sel   = w_accept ? dm_data_select_i          : r_sel;
    assign w_op_store = w_accept ? dm_store_i                : r_store;

    assign w_enter_done = (w_state_nxt == c_st_done);
    assign w_commit     = rst_n_i & w_enter_done & w_op_store;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= c_st_idle;
            r_cnt        <= 5'd0;
            r_idx        <= '0;
            r_data       <= 32'd0;
            r_sel        <= 4'd0;
            r_store      <= 1'b0;
            r_data_l     <= 32'd0;
            r_load_done  <= 1'b0;
            r_store_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_load_done  <= w_enter_done & ~w_op_store;
            r_store_done <= w_enter_done &  w_op_store;
            if (w_accept) begin
                r_idx   <= dm_addr_i[ADDR_WIDTH+1:2];
                r_data  <= dm_data_s_i;
                r_sel   <= dm_data_select_i;
                r_store <= dm_store_i;
            end
            if (w_enter_done && !w_op_store) begin
                r_data_l <= r_mem[w_op_idx];
            end
        end
    end

    // Storage has no reset; contents survive a reset of the control path.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_op_sel[b]) begin
                    r_mem[w_op_idx][8*b +: 8] <= w_op_data[8*b +: 8];
                end
            end
        end
    end

    assign w_unused_addr = ^{dm_addr_i[31:ADDR_WIDTH+2], dm_addr_i[1:0]};

    assign dm_ready_o      = w_ready;
    assign dm_data_l_o     = r_data_l;
    assign dm_load_done_o  = r_load_done;
    assign dm_store_done_o = r_store_done;

endmodule

`default_nettype wire
